// File: rtl/game_pkg.sv
// Shared constants and type definitions for the snake/Tron game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRun   = 3'd2,
    StStep  = 3'd3,
    StCheck = 3'd4,
    StDead  = 3'd5
  } game_state_e;

  typedef enum logic [4:0] {
    DirUp    = 5'b00010,
    DirLeft  = 5'b00100,
    DirDown  = 5'b01000,
    DirRight = 5'b10000
  } dir_e;

  localparam int unsigned DefMaxSize  = 127;
  localparam int unsigned DefInitSize = 1;
  localparam int unsigned BorderW     = 10;
  localparam int unsigned CellSize    = 10;

endpackage

// File: rtl/game_ctrl_if.sv
// Command/status bundle between the game sequencer and the rest of the game datapath.
interface game_ctrl_if #(
  parameter int unsigned SIZE_W = 7
);

  logic              start;
  logic              step_tick;
  logic              frame_end;
  logic              hit_lethal;
  logic              hit_apple;
  logic              apple_ack;
  logic              snake_clear;
  logic              snake_step;
  logic              snake_grow;
  logic [SIZE_W-1:0] size;
  logic              apple_req;
  logic [7:0]        score;
  logic              game_over;
  logic              flash;
  logic [2:0]        state;

  modport master (
    input  start, step_tick, frame_end, hit_lethal, hit_apple, apple_ack,
    output snake_clear, snake_step, snake_grow, size, apple_req, score, game_over, flash, state
  );

  modport slave (
    output start, step_tick, frame_end, hit_lethal, hit_apple, apple_ack,
    input  snake_clear, snake_step, snake_grow, size, apple_req, score, game_over, flash, state
  );

endinterface

// File: rtl/dead_timer.sv
// Counts frames after death and blinks flash every FLASH_DIV frames until DEAD_FRAMES elapse.
module dead_timer #(
  parameter int unsigned DEAD_FRAMES = 120,
  parameter int unsigned FLASH_DIV   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic frame_end,
  output logic flash
);

  localparam int unsigned CntW = $clog2(DEAD_FRAMES + 1);
  localparam int unsigned DivW = $clog2(FLASH_DIV + 1);

  logic [CntW-1:0] frame_cnt_q;
  logic [DivW-1:0] div_cnt_q;
  logic            flash_q;
  logic            done;

  assign done  = (frame_cnt_q == CntW'(DEAD_FRAMES));
  assign flash = flash_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      div_cnt_q   <= '0;
      flash_q     <= 1'b0;
    end else if (!en) begin
      frame_cnt_q <= '0;
      div_cnt_q   <= '0;
      flash_q     <= 1'b0;
    end else if (frame_end && !done) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
      // Last counted frame forces the blink off for good.
      if (frame_cnt_q == CntW'(DEAD_FRAMES - 1)) begin
        flash_q <= 1'b0;
      end else if (div_cnt_q == DivW'(FLASH_DIV - 1)) begin
        div_cnt_q <= '0;
        flash_q   <= ~flash_q;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: idle/clear/run/step/check/dead FSM, snake body commands and apple handshake.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned MAX_SIZE    = DefMaxSize,
  parameter int unsigned INIT_SIZE   = DefInitSize,
  parameter int unsigned SIZE_W      = 7,
  parameter int unsigned DEAD_FRAMES = 120,
  parameter int unsigned FLASH_DIV   = 8
) (
  input logic         VGA_clk,
  input logic         reset,
  game_ctrl_if.master bus
);

  localparam logic [SIZE_W-1:0] MaxSizeC  = SIZE_W'(MAX_SIZE);
  localparam logic [SIZE_W-1:0] InitSizeC = SIZE_W'(INIT_SIZE);

  game_state_e       state_q;
  logic              lethal_seen_q;
  logic              apple_seen_q;
  logic              step_pend_q;
  logic              snake_clear_q;
  logic              snake_step_q;
  logic              snake_grow_q;
  logic              apple_req_q;
  logic              game_over_q;
  logic [SIZE_W-1:0] size_q;
  logic [7:0]        score_q;
  logic              dead_flash;

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      lethal_seen_q <= 1'b0;
      apple_seen_q  <= 1'b0;
      step_pend_q   <= 1'b0;
      snake_clear_q <= 1'b0;
      snake_step_q  <= 1'b0;
      snake_grow_q  <= 1'b0;
      apple_req_q   <= 1'b0;
      game_over_q   <= 1'b0;
      size_q        <= InitSizeC;
      score_q       <= '0;
    end else begin
      snake_clear_q <= 1'b0;
      snake_step_q  <= 1'b0;
      snake_grow_q  <= 1'b0;
      game_over_q   <= 1'b0;

      if (apple_req_q && bus.apple_ack) apple_req_q <= 1'b0;

      if (state_q == StRun || state_q == StStep) begin
        lethal_seen_q <= lethal_seen_q | bus.hit_lethal;
        // Hits on the old apple position must not score while a new one is being placed.
        apple_seen_q  <= apple_seen_q | (bus.hit_apple & ~apple_req_q);
      end

      if (bus.step_tick && state_q != StIdle && state_q != StDead) step_pend_q <= 1'b1;

      if (state_q != StIdle && !bus.start) begin
        state_q       <= StIdle;
        apple_req_q   <= 1'b0;
        lethal_seen_q <= 1'b0;
        apple_seen_q  <= 1'b0;
        step_pend_q   <= 1'b0;
        size_q        <= InitSizeC;
      end else begin
        unique case (state_q)
          StIdle: begin
            size_q <= InitSizeC;
            if (bus.start) state_q <= StClear;
          end
          StClear: begin
            snake_clear_q <= 1'b1;
            score_q       <= '0;
            apple_req_q   <= 1'b1;
            lethal_seen_q <= 1'b0;
            apple_seen_q  <= 1'b0;
            step_pend_q   <= 1'b0;
            state_q       <= StRun;
          end
          StRun: begin
            if (bus.frame_end) state_q <= StCheck;
          end
          StCheck: begin
            lethal_seen_q <= 1'b0;
            apple_seen_q  <= 1'b0;
            if (lethal_seen_q) begin
              state_q     <= StDead;
              game_over_q <= 1'b1;
              step_pend_q <= 1'b0;
            end else begin
              if (apple_seen_q && !apple_req_q) begin
                if (score_q != 8'hFF) score_q <= score_q + 1'b1;
                apple_req_q <= 1'b1;
                if (size_q < MaxSizeC) begin
                  size_q       <= size_q + 1'b1;
                  snake_grow_q <= 1'b1;
                end
              end
              state_q <= step_pend_q ? StStep : StRun;
            end
          end
          StStep: begin
            snake_step_q <= 1'b1;
            // A tick arriving while the pending step is served becomes the next pending step.
            step_pend_q  <= bus.step_tick;
            state_q      <= StRun;
          end
          StDead: begin
            game_over_q <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  dead_timer #(
    .DEAD_FRAMES(DEAD_FRAMES),
    .FLASH_DIV  (FLASH_DIV)
  ) u_dead_timer (
    .clk      (VGA_clk),
    .rst      (reset),
    .en       (state_q == StDead),
    .frame_end(bus.frame_end),
    .flash    (dead_flash)
  );

  assign bus.snake_clear = snake_clear_q;
  assign bus.snake_step  = snake_step_q;
  assign bus.snake_grow  = snake_grow_q;
  assign bus.size        = size_q;
  assign bus.apple_req   = apple_req_q;
  assign bus.score       = score_q;
  assign bus.game_over   = game_over_q;
  assign bus.flash       = dead_flash;
  assign bus.state       = state_q;

endmodule
